phase_request_scheduler: RTL and testbench
==========================================

# phase_request_scheduler

Request scheduler for a single two-road intersection. It latches the pedestrian request, samples the side-road vehicle sensor and both emergency inputs, and arbitrates them by priority. It enforces minimum and maximum dwell times and issues one phase command at a time over a valid/ready handshake to the downstream lamp sequencer. The lamp sequencer owns red/yellow/green timing; this block decides which phase is next and when.

## Interface
- MIN_MAIN, 8: minimum main-green dwell in cycles (≥1)
- MAX_SIDE, 6: maximum side-green dwell in cycles (≥1)
- PED_TIME, 5: walk dwell in cycles (≥1)
- CNT_W, 8: dwell counter width; must hold max(MIN_MAIN, MAX_SIDE, PED_TIME)−1
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- side_veh  in  1  side-road vehicle present (level)
- ped  in  1  pedestrian button (level, latched internally)
- em_main  in  1  emergency vehicle on main road (level)
- em_side  in  1  emergency vehicle on side road (level)
- cmd_ready  in  1  lamp sequencer accepts command
- cmd_valid  out  1  phase command valid
- phase_cmd  out  2  0 = MAIN, 1 = SIDE, 2 = PED (all vehicle red), 3 = reserved, never issued
- active_phase  out  2  last accepted phase
- walk  out  1  walk lamp, high throughout PED hold
- ped_ack  out  1  one-cycle pulse when a PED command is accepted

## Operation
- States: INIT, ISSUE, MAIN_HOLD, SIDE_HOLD, PED_HOLD.
- Reset values: state=INIT, cmd_valid=0, phase_cmd=0, active_phase=MAIN, walk=0, ped_ack=0, ped_pend=0, dwell_cnt=0.
- INIT → ISSUE on the first edge after reset release, with phase_cmd=MAIN.
- ISSUE: cmd_valid=1. phase_cmd holds stable until a handshake (cmd_valid & cmd_ready at a rising edge).
- On handshake:
  - active_phase ← phase_cmd; move to the matching HOLD state; dwell_cnt ← T−1, where T is MIN_MAIN, MAX_SIDE or PED_TIME.
  - cmd_valid ← 0.
  - For PED: ped_ack pulses and ped_pend clears.
- ped_pend is set whenever ped=1. Set wins over a same-cycle clear.
- A HOLD state decrements dwell_cnt each cycle while it is nonzero. "Expired" means dwell_cnt==0.
- Emergency preemption, evaluated in every HOLD state each cycle, highest priority:
  - If em_main=1 and active_phase≠MAIN: go to ISSUE with MAIN next edge.
  - Else if em_side=1 and active_phase≠SIDE: go to ISSUE with SIDE.
  - If both are asserted, em_main wins.
  - Preemption ignores dwell_cnt. A PED hold is cut short and walk drops.
- MAIN_HOLD, when expired and no emergency:
  - ped_pend=1 → ISSUE PED.
  - Else side_veh=1 → ISSUE SIDE.
  - Else remain in MAIN_HOLD indefinitely with no command issued.
- MAIN_HOLD while em_main=1: never leaves.
- SIDE_HOLD:
  - While em_side=1: never leaves.
  - Otherwise, on expiry or side_veh=0 → ISSUE MAIN.
- PED_HOLD: walk=1; on expiry → ISSUE MAIN.
- Emergency or pedestrian requests arriving during ISSUE do not alter the pending command. They are evaluated from the HOLD state entered after the handshake.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous). A pending command is abandoned.

## Timing
- All outputs are registered.
- The decision edge and the first cmd_valid=1 cycle coincide: cmd_valid rises one edge after the deciding condition is sampled.
- A HOLD state without preemption lasts exactly T cycles after the handshake edge.
- Pedestrian latency is bounded by MIN_MAIN + the handshake wait, assuming no emergency.
- Back-to-back: with cmd_ready tied high, ISSUE lasts one cycle.

## Structure
- Package traffic_pkg holds:
  - phase codes PH_MAIN=2'd0, PH_SIDE=2'd1, PH_PED=2'd2;
  - state encoding;
  - default timing constants, shared with the lamp sequencer.
- Sub-module dwell_timer: load / decrement / expired, CNT_W wide. It is instantiated once.

## Test plan
- Reset startup, cmd_ready=1:
  - rst low then high → cmd_valid=1 with MAIN on the 1st edge;
  - active_phase=MAIN on the 2nd edge;
  - with side_veh=1, SIDE is issued exactly 8 cycles after the MAIN handshake.
- Pedestrian: ped pulse of 1 cycle during MAIN_HOLD → PED is issued at expiry; ped_ack is a 1-cycle pulse; walk=1 for 5 cycles; then MAIN is issued.
- Side max dwell: side_veh held at 1 → SIDE_HOLD lasts 6 cycles, then MAIN. side_veh dropping at cycle 2 → MAIN is issued on the next edge.
- Emergency:
  - em_main=1 during PED_HOLD cycle 2 → walk=0 and MAIN is issued on the next edge;
  - em_main=em_side=1 from SIDE_HOLD → MAIN wins;
  - em_side=1 holds SIDE past 6 cycles.
- Backpressure: cmd_ready=0 for 4 cycles → phase_cmd stable and cmd_valid=1 throughout. An em_side toggle during the wait does not change phase_cmd.
- Reset mid-ISSUE: rst low while cmd_valid=1 → all outputs return to reset values in the same cycle; the sequence restarts with MAIN.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared phase codes, scheduler state encoding and default dwell constants.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package traffic_pkg;

    // Phase codes exchanged with the lamp sequencer; PH_RSVD is never issued.
    typedef enum logic [1:0] {
        PH_MAIN = 2'd0,
        PH_SIDE = 2'd1,
        PH_PED  = 2'd2,
        PH_RSVD = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_MAIN_HOLD = 3'd2,
        ST_SIDE_HOLD = 3'd3,
        ST_PED_HOLD  = 3'd4
    } state_e;

    // Default dwell times in clock cycles, also used by the lamp sequencer.
    localparam int DEF_MIN_MAIN = 8;
    localparam int DEF_MAX_SIDE = 6;
    localparam int DEF_PED_TIME = 5;
    localparam int DEF_CNT_W    = 8;

endpackage

// File: rtl/phase_request_scheduler_if.sv
// Phase command channel from the scheduler to the lamp sequencer.
// Latency: n/a (wires only); a transfer happens on cmd_valid & cmd_ready at a rising edge.
// Backpressure: the sender holds phase_cmd stable while cmd_valid is high and cmd_ready is low.
//   cmd_valid : phase command valid (scheduler -> sequencer)
//   phase_cmd : 2-bit phase code    (scheduler -> sequencer)
//   cmd_ready : sequencer accepts   (sequencer -> scheduler)
interface phase_request_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] phase_cmd;

    modport master (output cmd_valid, output phase_cmd, input  cmd_ready);
    modport slave  (input  cmd_valid, input  phase_cmd, output cmd_ready);
endinterface

// File: rtl/phase_request_scheduler_dwell_timer.sv
// Dwell down-counter: load a start value, count down to zero, flag expiry.
// Latency: load/decrement visible one cycle after the request; expired is combinational on the count.
// Backpressure: none; decrement saturates at zero.
//   clk, rst    : clock, async active-low reset (count -> 0)
//   load/load_val : load start value (wins over dec)
//   dec         : decrement while nonzero
//   cnt/expired : current count, count==0
module dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             expired
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign expired = (cnt_q == '0);
endmodule

// File: rtl/phase_request_scheduler.sv
// Intersection phase scheduler: arbitrates emergency/pedestrian/side requests and issues phase commands.
// Latency: command issued one edge after the deciding condition; a HOLD lasts T cycles after the handshake.
// Backpressure: cmd_valid/phase_cmd held stable in ISSUE until cmd_ready; requests during the wait are deferred.
//   clk, rst                       : clock, async active-low reset
//   side_veh, ped, em_main, em_side : level request inputs (ped is latched)
//   cmd_if (master)                : cmd_valid / phase_cmd / cmd_ready
//   active_phase                   : last accepted phase
//   walk                           : high throughout the pedestrian hold
//   ped_ack                        : one-cycle pulse when a PED command is accepted
module phase_request_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_MAIN = DEF_MIN_MAIN,
    parameter int MAX_SIDE = DEF_MAX_SIDE,
    parameter int PED_TIME = DEF_PED_TIME,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       side_veh,
    input  logic                       ped,
    input  logic                       em_main,
    input  logic                       em_side,
    phase_request_scheduler_if.master  cmd_if,
    output logic [1:0]                 active_phase,
    output logic                       walk,
    output logic                       ped_ack
);
    localparam logic [CNT_W-1:0] LD_MAIN = CNT_W'(MIN_MAIN - 1);
    localparam logic [CNT_W-1:0] LD_SIDE = CNT_W'(MAX_SIDE - 1);
    localparam logic [CNT_W-1:0] LD_PED  = CNT_W'(PED_TIME - 1);

    state_e     state_q, state_d;
    logic       cmd_valid_q, cmd_valid_d;
    phase_e     phase_cmd_q, phase_cmd_d;
    phase_e     active_phase_q, active_phase_d;
    logic       walk_q, walk_d;
    logic       ped_ack_q, ped_ack_d;
    logic       ped_pend_q, ped_pend_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_dec;
    logic [CNT_W-1:0] dwell_cnt;
    logic             expired;

    logic             hs;
    logic             issue;
    phase_e           issue_ph;

    assign hs = cmd_valid_q & cmd_if.cmd_ready;

    dwell_timer #(.CNT_W(CNT_W)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .cnt      (dwell_cnt),
        .expired  (expired)
    );

    always_comb begin
        state_d        = state_q;
        cmd_valid_d    = cmd_valid_q;
        phase_cmd_d    = phase_cmd_q;
        active_phase_d = active_phase_q;
        ped_ack_d      = 1'b0;
        // A button press in the same cycle as the PED handshake keeps the request pending.
        ped_pend_d     = ped | ped_pend_q;
        tmr_load       = 1'b0;
        tmr_val        = '0;
        tmr_dec        = 1'b0;
        issue          = 1'b0;
        issue_ph       = PH_MAIN;

        case (state_q)
            ST_INIT: begin
                issue    = 1'b1;
                issue_ph = PH_MAIN;
            end
            ST_ISSUE: begin
                // Requests arriving here are ignored until the matching HOLD state is entered.
                if (hs) begin
                    cmd_valid_d    = 1'b0;
                    active_phase_d = phase_cmd_q;
                    tmr_load       = 1'b1;
                    case (phase_cmd_q)
                        PH_SIDE: begin
                            state_d = ST_SIDE_HOLD;
                            tmr_val = LD_SIDE;
                        end
                        PH_PED: begin
                            state_d    = ST_PED_HOLD;
                            tmr_val    = LD_PED;
                            ped_ack_d  = 1'b1;
                            ped_pend_d = ped;
                        end
                        default: begin
                            state_d = ST_MAIN_HOLD;
                            tmr_val = LD_MAIN;
                        end
                    endcase
                end
            end
            ST_MAIN_HOLD: begin
                tmr_dec = 1'b1;
                if (em_main) begin
                    // Main emergency pins the main green regardless of other requests.
                end else if (em_side) begin
                    issue    = 1'b1;
                    issue_ph = PH_SIDE;
                end else if (expired && ped_pend_q) begin
                    issue    = 1'b1;
                    issue_ph = PH_PED;
                end else if (expired && side_veh) begin
                    issue    = 1'b1;
                    issue_ph = PH_SIDE;
                end
            end
            ST_SIDE_HOLD: begin
                tmr_dec = 1'b1;
                if (em_main) begin
                    issue    = 1'b1;
                    issue_ph = PH_MAIN;
                end else if (em_side) begin
                    // Side emergency extends the side green past its maximum.
                end else if (expired || !side_veh) begin
                    issue    = 1'b1;
                    issue_ph = PH_MAIN;
                end
            end
            ST_PED_HOLD: begin
                tmr_dec = 1'b1;
                if (em_main) begin
                    issue    = 1'b1;
                    issue_ph = PH_MAIN;
                end else if (em_side) begin
                    issue    = 1'b1;
                    issue_ph = PH_SIDE;
                end else if (expired) begin
                    issue    = 1'b1;
                    issue_ph = PH_MAIN;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (issue) begin
            state_d     = ST_ISSUE;
            cmd_valid_d = 1'b1;
            phase_cmd_d = issue_ph;
        end

        // Walk follows the PED hold exactly, so preemption drops it on the same edge.
        walk_d = (state_d == ST_PED_HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_INIT;
            cmd_valid_q    <= 1'b0;
            phase_cmd_q    <= PH_MAIN;
            active_phase_q <= PH_MAIN;
            walk_q         <= 1'b0;
            ped_ack_q      <= 1'b0;
            ped_pend_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd_valid_q    <= cmd_valid_d;
            phase_cmd_q    <= phase_cmd_d;
            active_phase_q <= active_phase_d;
            walk_q         <= walk_d;
            ped_ack_q      <= ped_ack_d;
            ped_pend_q     <= ped_pend_d;
        end
    end

    assign cmd_if.cmd_valid = cmd_valid_q;
    assign cmd_if.phase_cmd = phase_cmd_q;
    assign active_phase     = active_phase_q;
    assign walk             = walk_q;
    assign ped_ack          = ped_ack_q;
endmodule

// File: tb/tb_phase_request_scheduler.sv
// Self-checking bench for phase_request_scheduler: vector table plus directed corner sequences.
// Latency: n/a.
// Backpressure: cmd_ready driven by the bench; handshakes scored against a queue of expected phases.
module tb_phase_request_scheduler;
    localparam int P_MAIN = 0;
    localparam int P_SIDE = 1;
    localparam int P_PED  = 2;

    logic clk;
    logic rst;
    logic side_veh, ped, em_main, em_side;
    logic [1:0] active_phase;
    logic walk, ped_ack;

    phase_request_scheduler_if bus();

    phase_request_scheduler #(
        .MIN_MAIN (8),
        .MAX_SIDE (6),
        .PED_TIME (5),
        .CNT_W    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .side_veh     (side_veh),
        .ped          (ped),
        .em_main      (em_main),
        .em_side      (em_side),
        .cmd_if       (bus),
        .active_phase (active_phase),
        .walk         (walk),
        .ped_ack      (ped_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;
    int sb[$];

    typedef struct {
        logic sv, pd, em, es, rdy;
        logic ev;
        int   ec;
        int   ea;
        logic ew, ek;
    } vec_t;
    vec_t vt[$];

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic sv, input logic rdy, input logic ev, input int ec, input int ea,
                       input logic ew, input logic ek);
        vec_t v;
        v.sv = sv; v.pd = 1'b0; v.em = 1'b0; v.es = 1'b0; v.rdy = rdy;
        v.ev = ev; v.ec = ec; v.ea = ea; v.ew = ew; v.ek = ek;
        vt.push_back(v);
    endtask

    // Expect the next command (phase ph) to become valid after exactly n edges.
    task automatic wait_valid(input string nm, input int n, input int ph);
        int k;
        sb.push_back(ph);
        k = 0;
        do begin
            step();
            k++;
        end while (!bus.cmd_valid && k < 40);
        check(nm, k, n);
    endtask

    // Scoreboard: a handshake will occur on the coming rising edge.
    always @(negedge clk) begin
        if (rst && bus.cmd_valid && bus.cmd_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_cmd", int'(bus.phase_cmd), -1);
            end else begin
                check("handshake_phase", int'(bus.phase_cmd), sb.pop_front());
            end
        end
    end

    initial begin
        logic prev_v;
        int nw, na, g, nv;

        rst = 1'b0; side_veh = 1'b0; ped = 1'b0; em_main = 1'b0; em_side = 1'b0;
        bus.cmd_ready = 1'b1;

        // Startup with side traffic waiting: MAIN, then SIDE after 8, then MAIN after 6.
        add(1, 1, 1, P_MAIN, P_MAIN, 0, 0);
        add(1, 1, 0, P_MAIN, P_MAIN, 0, 0);
        for (int i = 0; i < 7; i++) add(1, 1, 0, P_MAIN, P_MAIN, 0, 0);
        add(1, 1, 1, P_SIDE, P_MAIN, 0, 0);
        add(1, 1, 0, P_SIDE, P_SIDE, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 1, 0, P_SIDE, P_SIDE, 0, 0);
        add(1, 1, 1, P_MAIN, P_SIDE, 0, 0);
        add(1, 1, 0, P_MAIN, P_MAIN, 0, 0);

        step(); step();
        check("rst_valid", int'(bus.cmd_valid), 0);
        check("rst_phase", int'(bus.phase_cmd), P_MAIN);
        check("rst_active", int'(active_phase), P_MAIN);
        check("rst_walk", int'(walk), 0);
        check("rst_ack", int'(ped_ack), 0);
        rst = 1'b1;

        prev_v = 1'b0;
        foreach (vt[i]) begin
            side_veh = vt[i].sv; ped = vt[i].pd; em_main = vt[i].em; em_side = vt[i].es;
            bus.cmd_ready = vt[i].rdy;
            step();
            check($sformatf("vec%0d_valid", i), int'(bus.cmd_valid), int'(vt[i].ev));
            check($sformatf("vec%0d_phase", i), int'(bus.phase_cmd), vt[i].ec);
            check($sformatf("vec%0d_active", i), int'(active_phase), vt[i].ea);
            check($sformatf("vec%0d_walk", i), int'(walk), int'(vt[i].ew));
            check($sformatf("vec%0d_ack", i), int'(ped_ack), int'(vt[i].ek));
            if (vt[i].ev && !prev_v) sb.push_back(vt[i].ec);
            prev_v = vt[i].ev;
        end

        // Pedestrian: 1-cycle press in MAIN_HOLD, PED at expiry, 5 walk cycles, then MAIN.
        side_veh = 1'b0;
        ped = 1'b1;
        step();
        ped = 1'b0;
        wait_valid("ped_issue_lat", 7, P_PED);
        step();
        check("ped_ack_pulse", int'(ped_ack), 1);
        check("ped_walk_on", int'(walk), 1);
        check("ped_active", int'(active_phase), P_PED);
        nw = 1; na = 1; g = 0;
        while (!bus.cmd_valid && g < 20) begin
            step();
            if (walk) nw++;
            if (ped_ack) na++;
            g++;
        end
        sb.push_back(P_MAIN);
        check("ped_walk_cycles", nw, 5);
        check("ped_ack_count", na, 1);
        check("ped_then_main_valid", int'(bus.cmd_valid), 1);
        step();

        // Side green cut short when the side queue empties in hold cycle 2.
        side_veh = 1'b1;
        wait_valid("side_issue_lat", 8, P_SIDE);
        step();
        check("side_hold_c1_valid", int'(bus.cmd_valid), 0);
        check("side_hold_active", int'(active_phase), P_SIDE);
        step();
        check("side_hold_c2_valid", int'(bus.cmd_valid), 0);
        side_veh = 1'b0;
        wait_valid("side_drop_lat", 1, P_MAIN);
        step();

        // em_side extends SIDE past its maximum dwell.
        side_veh = 1'b1;
        wait_valid("em_side_setup", 8, P_SIDE);
        step();
        em_side = 1'b1;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.cmd_valid) nv++;
        end
        check("em_side_hold_no_cmd", nv, 0);
        em_side = 1'b0;
        wait_valid("em_side_release", 1, P_MAIN);
        step();

        // Both emergencies from SIDE_HOLD: MAIN wins and is then pinned.
        wait_valid("both_em_setup", 8, P_SIDE);
        step();
        em_main = 1'b1; em_side = 1'b1;
        wait_valid("both_em_main_wins", 1, P_MAIN);
        step();
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.cmd_valid) nv++;
        end
        check("em_main_pins_main", nv, 0);
        em_main = 1'b0;
        wait_valid("em_side_preempt_main", 1, P_SIDE);
        em_side = 1'b0; side_veh = 1'b0;
        step();
        wait_valid("side_empty_release", 1, P_MAIN);
        step();

        // em_main in PED hold cycle 2 drops walk and issues MAIN next edge.
        ped = 1'b1;
        step();
        ped = 1'b0;
        wait_valid("ped2_issue_lat", 7, P_PED);
        step();
        step();
        check("ped2_walk_c2", int'(walk), 1);
        em_main = 1'b1;
        wait_valid("ped_preempt_lat", 1, P_MAIN);
        check("ped_preempt_walk", int'(walk), 0);
        em_main = 1'b0;
        step();

        // Backpressure: command held stable, em_side toggle ignored during ISSUE.
        side_veh = 1'b1;
        bus.cmd_ready = 1'b0;
        wait_valid("bp_issue_lat", 8, P_SIDE);
        for (int i = 0; i < 4; i++) begin
            em_side = (i == 1 || i == 2);
            step();
            check($sformatf("bp%0d_valid", i), int'(bus.cmd_valid), 1);
            check($sformatf("bp%0d_phase", i), int'(bus.phase_cmd), P_SIDE);
        end
        em_side = 1'b0;
        bus.cmd_ready = 1'b1;
        step();
        check("bp_active", int'(active_phase), P_SIDE);
        side_veh = 1'b0;
        wait_valid("bp_release", 1, P_MAIN);
        step();

        // Reset while a command is pending: immediate reset values, restart with MAIN.
        side_veh = 1'b1;
        bus.cmd_ready = 1'b0;
        wait_valid("rst2_setup", 8, P_SIDE);
        rst = 1'b0;
        #1;
        check("rst2_valid", int'(bus.cmd_valid), 0);
        check("rst2_phase", int'(bus.phase_cmd), P_MAIN);
        check("rst2_active", int'(active_phase), P_MAIN);
        check("rst2_walk", int'(walk), 0);
        check("rst2_ack", int'(ped_ack), 0);
        sb.delete();
        step(); step();
        rst = 1'b1;
        bus.cmd_ready = 1'b1;
        side_veh = 1'b0;
        wait_valid("rst2_restart", 1, P_MAIN);
        step();
        check("rst2_restart_active", int'(active_phase), P_MAIN);
        check("rst2_restart_valid", int'(bus.cmd_valid), 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
